// File: rtl/simd_acc_pkg.sv
// Shared types for the SIMD accumulator bank: op encoding, pipeline/history records and FSM
// states.
package simd_acc_pkg;

    // Record widths track the default bank geometry of simd_accumulator.
    localparam int unsigned ACC_ADDR_WIDTH = 9;
    localparam int unsigned ACC_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        OP_WR   = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_SADD = 2'b11
    } acc_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRAIN = 2'b01,
        CLEAR = 2'b10
    } clr_state_t;

    typedef struct packed {
        logic                      valid;
        acc_op_t                   op;
        logic [ACC_ADDR_WIDTH-1:0] addr;
        logic [ACC_DATA_WIDTH-1:0] data;
    } pipe_stage_t;

    typedef struct packed {
        logic                      valid;
        logic [ACC_ADDR_WIDTH-1:0] addr;
        logic [ACC_DATA_WIDTH-1:0] data;
    } hist_entry_t;

    function automatic logic hist_hit(hist_entry_t e, logic [ACC_ADDR_WIDTH-1:0] addr);
        return e.valid && (e.addr == addr);
    endfunction

endpackage

// File: rtl/acc_lane_alu.sv
// One SIMD lane of the accumulate ALU: overwrite, wrap add, wrap subtract, signed saturating add.
module acc_lane_alu
    import simd_acc_pkg::*;
#(
    parameter int unsigned LANE_WIDTH = 16
) (
    input  acc_op_t               op,
    input  logic [LANE_WIDTH-1:0] base,
    input  logic [LANE_WIDTH-1:0] data,
    output logic [LANE_WIDTH-1:0] result,
    output logic                  sat
);

    localparam logic [LANE_WIDTH-1:0] SMAX = {1'b0, {(LANE_WIDTH-1){1'b1}}};
    localparam logic [LANE_WIDTH-1:0] SMIN = {1'b1, {(LANE_WIDTH-1){1'b0}}};

    logic [LANE_WIDTH:0] sum_ext;

    always_comb begin
        sum_ext = {base[LANE_WIDTH-1], base} + {data[LANE_WIDTH-1], data};
        result  = data;
        sat     = 1'b0;
        unique case (op)
            OP_WR:  result = data;
            OP_ADD: result = base + data;
            OP_SUB: result = base - data;
            OP_SADD: begin
                // Sign-extended sum disagrees in its top two bits exactly on overflow.
                if (sum_ext[LANE_WIDTH] != sum_ext[LANE_WIDTH-1]) begin
                    sat    = 1'b1;
                    result = sum_ext[LANE_WIDTH] ? SMIN : SMAX;
                end else begin
                    result = sum_ext[LANE_WIDTH-1:0];
                end
            end
            default: result = data;
        endcase
    end

endmodule

// File: rtl/pseudo_dpram.sv
// Pseudo-dual-port RAM: one write port, one read port with RD_LAT cycles of read latency.
// Read-first on a same-address collision; contents are never reset.
module pseudo_dpram #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_pipe_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                rd_pipe_q[i] <= '0;
            end
        end else begin
            if (re) begin
                rd_pipe_q[0] <= mem[raddr];
            end
            for (int i = 1; i < int'(RD_LAT); i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
        end
    end

    assign rdata = rd_pipe_q[RD_LAT-1];

endmodule

// File: rtl/simd_accumulator.sv
// Read-modify-write SIMD accumulator bank over a pseudo-dual-port RAM, with hazard forwarding,
// read-port arbitration and a hardware clear sweep.
module simd_accumulator
    import simd_acc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ACC_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = ACC_DATA_WIDTH,
    parameter int unsigned LANE_WIDTH = 16,
    parameter int unsigned RAM_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    output logic                  wr_ready,
    input  logic [1:0]            wr_op,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  clr_start,
    output logic                  busy,
    output logic                  clr_done,
    output logic                  sat_flag
);

    localparam int unsigned NUM_LANES  = DATA_WIDTH / LANE_WIDTH;
    localparam int unsigned HIST_DEPTH = RAM_LAT + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    clr_state_t            state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic                  ports_open_q;
    logic                  busy_q;
    logic                  clr_done_q;

    pipe_stage_t           pipe_q [RAM_LAT];
    hist_entry_t           hist_q [HIST_DEPTH];
    logic [RAM_LAT-1:0]    rd_pend_q;

    acc_op_t               req_op;
    logic                  wr_fire;
    logic                  int_rd;
    logic                  ext_rd;
    logic                  pipe_busy;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    pipe_stage_t           alu_stage;
    logic [DATA_WIDTH-1:0] alu_base;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [NUM_LANES-1:0]  lane_sat;

    // Request side and read-port arbitration; the internal RMW read always wins.
    assign req_op   = acc_op_t'(wr_op);
    assign wr_ready = ports_open_q;
    assign wr_fire  = wr_en && ports_open_q;
    assign int_rd   = wr_fire && (req_op != OP_WR);
    assign rd_ready = ports_open_q && !int_rd;
    assign ext_rd   = rd_en && rd_ready;

    assign ram_re    = int_rd || ext_rd;
    assign ram_raddr = int_rd ? wr_addr : rd_addr;

    // The sweep only runs once the pipeline has drained, so it owns the write port outright.
    always_comb begin
        ram_we    = hist_q[0].valid;
        ram_waddr = hist_q[0].addr;
        ram_wdata = hist_q[0].data;
        if (state_q == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr_q;
            ram_wdata = '0;
        end
    end

    pseudo_dpram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LAT     (RAM_LAT)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign alu_stage = pipe_q[RAM_LAT-1];

    // Oldest-first scan so the youngest matching in-flight result ends up as the base.
    always_comb begin
        alu_base = ram_rdata;
        for (int i = int'(HIST_DEPTH) - 1; i >= 0; i--) begin
            if (hist_hit(hist_q[i], alu_stage.addr)) begin
                alu_base = hist_q[i].data;
            end
        end
    end

    for (genvar l = 0; l < int'(NUM_LANES); l++) begin : g_lane
        acc_lane_alu #(
            .LANE_WIDTH (LANE_WIDTH)
        ) u_alu (
            .op     (alu_stage.op),
            .base   (alu_base[l*LANE_WIDTH +: LANE_WIDTH]),
            .data   (alu_stage.data[l*LANE_WIDTH +: LANE_WIDTH]),
            .result (alu_result[l*LANE_WIDTH +: LANE_WIDTH]),
            .sat    (lane_sat[l])
        );
    end

    assign sat_flag = alu_stage.valid && (|lane_sat);

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < int'(RAM_LAT); i++) begin
            pipe_busy = pipe_busy | pipe_q[i].valid;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(RAM_LAT); i++) begin
                pipe_q[i] <= '0;
            end
            for (int i = 0; i < int'(HIST_DEPTH); i++) begin
                hist_q[i] <= '0;
            end
            rd_pend_q <= '0;
        end else begin
            pipe_q[0] <= '{valid: wr_fire, op: req_op, addr: wr_addr, data: wr_data};
            for (int i = 1; i < int'(RAM_LAT); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            hist_q[0] <= '{valid: alu_stage.valid, addr: alu_stage.addr, data: alu_result};
            for (int i = 1; i < int'(HIST_DEPTH); i++) begin
                hist_q[i] <= hist_q[i-1];
            end
            rd_pend_q[0] <= ext_rd;
            for (int i = 1; i < int'(RAM_LAT); i++) begin
                rd_pend_q[i] <= rd_pend_q[i-1];
            end
        end
    end

    assign rd_valid = rd_pend_q[RAM_LAT-1];
    assign rd_data  = ram_rdata;

    // Clear sweep FSM. DRAIN may hand over while the last result is still in hist_q[0]: that
    // write lands on the same edge, and the sweep's first write is one cycle later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            clr_addr_q   <= '0;
            ports_open_q <= 1'b1;
            busy_q       <= 1'b0;
            clr_done_q   <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (clr_start) begin
                        state_q      <= DRAIN;
                        ports_open_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        state_q    <= CLEAR;
                        clr_addr_q <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q      <= IDLE;
                        clr_done_q   <= 1'b1;
                        ports_open_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_simd_accumulator.sv
// Self-checking bench for simd_accumulator: directed steps plus randomized accumulate traffic
// against a lane-arithmetic reference model.
module tb_simd_accumulator;

    localparam int AW      = 9;
    localparam int DW      = 64;
    localparam int LW      = 16;
    localparam int RAM_LAT = 2;
    localparam int DEPTH   = 1 << AW;

    logic          clk;
    logic          rstn;
    logic          wr_en;
    logic          wr_ready;
    logic [1:0]    wr_op;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          clr_start;
    logic          busy;
    logic          clr_done;
    logic          sat_flag;

    simd_accumulator #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LANE_WIDTH (LW),
        .RAM_LAT    (RAM_LAT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en     (wr_en),
        .wr_ready  (wr_ready),
        .wr_op     (wr_op),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_done  (clr_done),
        .sat_flag  (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            sat_seen = 0;
    int            sat_exp  = 0;
    logic          rd_rdy_seen;
    logic [DW-1:0] model [DEPTH];

    always @(negedge clk) begin
        if (sat_flag) sat_seen <= sat_seen + 1;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Per-lane reference: plain integer arithmetic, reduced mod 2**LW or clamped.
    function automatic logic [DW-1:0] model_op(input logic [1:0] op, input logic [DW-1:0] base,
                                               input logic [DW-1:0] data, output bit clipped);
        logic [DW-1:0] r;
        int ua, ub, sa, sb, s;
        clipped = 1'b0;
        r = '0;
        for (int l = 0; l < DW / LW; l++) begin
            ua = int'(base[l*LW +: LW]);
            ub = int'(data[l*LW +: LW]);
            sa = (ua >= (1 << (LW - 1))) ? ua - (1 << LW) : ua;
            sb = (ub >= (1 << (LW - 1))) ? ub - (1 << LW) : ub;
            case (op)
                2'd0: s = ub;
                2'd1: s = ua + ub;
                2'd2: s = ua - ub;
                default: begin
                    s = sa + sb;
                    if (s > (1 << (LW - 1)) - 1) begin
                        s = (1 << (LW - 1)) - 1;
                        clipped = 1'b1;
                    end else if (s < -(1 << (LW - 1))) begin
                        s = -(1 << (LW - 1));
                        clipped = 1'b1;
                    end
                end
            endcase
            r[l*LW +: LW] = s[LW-1:0];
        end
        return r;
    endfunction

    // Entered and left at posedge+1; the request is accepted on the edge inside.
    task automatic issue(input logic [1:0] op, input int addr, input logic [DW-1:0] data);
        bit c;
        wr_en   = 1'b1;
        wr_op   = op;
        wr_addr = addr[AW-1:0];
        wr_data = data;
        model[addr] = model_op(op, model[addr], data, c);
        if (c) sat_exp++;
        @(negedge clk);
        rd_rdy_seen = rd_ready;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string tag, input int addr, input logic [DW-1:0] exp);
        int waited;
        idle(RAM_LAT + 2);
        rd_en   = 1'b1;
        rd_addr = addr[AW-1:0];
        waited  = 0;
        @(negedge clk);
        while (!rd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        repeat (RAM_LAT - 1) @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, {63'd0, rd_valid}, 64'd1);
        check(tag, rd_data, exp);
        @(posedge clk);
        #1;
    endtask

    // Waits for clr_done from posedge+1 after the clr_start edge; returns edges elapsed.
    task automatic wait_clear(input bit restart_mid, output int cnt);
        cnt = 0;
        while (!clr_done && cnt < 3000) begin
            @(posedge clk);
            #1;
            cnt++;
            clr_start = restart_mid && (cnt == 200);
        end
        clr_start = 1'b0;
    endtask

    initial begin
        int            cnt;
        int            s0;
        int            e0;
        logic          any_rdy;
        logic [DW-1:0] d;
        logic [1:0]    op;
        logic [RAM_LAT-1:0] vld_hist;

        rstn = 1'b0; wr_en = 1'b0; wr_op = 2'd0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; clr_start = 1'b0;
        #12;
        check("reset_flags", {58'd0, wr_ready, rd_ready, rd_valid, busy, clr_done, sat_flag},
              64'b110000);
        check("reset_rd_data", rd_data, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Initial sweep on an idle pipeline, with a second start mid-sweep that must be ignored.
        clr_start = 1'b1;
        @(posedge clk);
        #1;
        clr_start = 1'b0;
        check("clr_busy_gate", {61'd0, busy, wr_ready, rd_ready}, 64'b100);
        wait_clear(1'b1, cnt);
        check("clr_len_idle", 64'(cnt), 64'(1 + DEPTH));
        check("clr_end_ready", {62'd0, busy, wr_ready}, 64'b01);
        idle(1);
        check("clr_done_pulse", {62'd0, clr_done, busy}, 64'b00);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        issue(2'd0, 5, 64'h0001_0002_0003_0004);
        issue(2'd1, 5, 64'h0001_0002_0003_0004);
        read_check("ovw_then_add", 5, 64'h0002_0004_0006_0008);

        repeat (4) issue(2'd1, 7, 64'h0001_0001_0001_0001);
        read_check("hazard_chain", 7, 64'h0004_0004_0004_0004);
        issue(2'd1, 9, 64'h0001_0001_0001_0001);
        issue(2'd1, 10, 64'h0001_0001_0001_0001);
        issue(2'd1, 9, 64'h0001_0001_0001_0001);
        read_check("interleave_a", 9, 64'h0002_0002_0002_0002);
        read_check("interleave_b", 10, 64'h0001_0001_0001_0001);

        issue(2'd0, 20, 64'h7FFF_FFFF_7FFF_FFFF);
        idle(RAM_LAT + 2);
        s0 = sat_seen;
        issue(2'd3, 20, 64'h0001_0001_0001_0001);
        read_check("sadd_clip", 20, 64'h7FFF_0000_7FFF_0000);
        check("sadd_sat_pulse", 64'(sat_seen - s0), 64'd1);
        issue(2'd0, 21, 64'h7FFF_FFFF_7FFF_FFFF);
        idle(RAM_LAT + 2);
        s0 = sat_seen;
        issue(2'd1, 21, 64'h0001_0001_0001_0001);
        read_check("wrap_add", 21, 64'h8000_0000_8000_0000);
        check("wrap_add_no_sat", 64'(sat_seen - s0), 64'd0);
        issue(2'd2, 22, 64'h0001_0001_0001_0001);
        read_check("wrap_sub", 22, 64'hFFFF_FFFF_FFFF_FFFF);

        // Randomized traffic on a narrow address window so hazards are frequent.
        s0 = sat_seen;
        e0 = sat_exp;
        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom_range(0, 3));
            d  = {$urandom, $urandom};
            issue(op, 32 + $urandom_range(0, 7), d);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(RAM_LAT + 3);
        check("rand_sat_count", 64'(sat_seen - s0), 64'(sat_exp - e0));
        for (int a = 32; a < 40; a++) read_check("rand_word", a, model[a]);

        // External read held against continuous RMW traffic.
        rd_en   = 1'b1;
        rd_addr = 9'd33;
        any_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            issue(2'd1, 50, 64'h0003_0003_0003_0003);
            any_rdy = any_rdy | rd_rdy_seen;
        end
        check("arb_stalled", {63'd0, any_rdy}, 64'd0);
        @(negedge clk);
        check("arb_released", {63'd0, rd_ready}, 64'd1);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        vld_hist = '0;
        for (int k = 0; k < RAM_LAT; k++) begin
            @(negedge clk);
            vld_hist[k] = rd_valid;
            if (k == RAM_LAT - 1) check("arb_data", rd_data, model[33]);
            @(posedge clk);
            #1;
        end
        check("arb_latency", 64'(vld_hist), 64'(1 << (RAM_LAT - 1)));
        read_check("arb_traffic_word", 50, model[50]);

        // Sweep started together with an accepted write; the write is drained then cleared.
        clr_start = 1'b1;
        issue(2'd0, 40, 64'hDEAD_BEEF_0123_4567);
        clr_start = 1'b0;
        check("clr2_gate", {61'd0, busy, wr_ready, rd_ready}, 64'b100);
        wait_clear(1'b0, cnt);
        check("clr_len_drain", 64'(cnt), 64'(RAM_LAT + 1 + DEPTH));
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        read_check("clr_word40", 40, 64'd0);
        read_check("clr_word35", 35, 64'd0);

        // Reset while the sweep counter sits at address 100.
        issue(2'd0, 99, 64'h1111_2222_3333_4444);
        issue(2'd0, 100, 64'h5555_6666_7777_8888);
        issue(2'd0, 101, 64'h9999_AAAA_BBBB_CCCC);
        issue(2'd0, 511, 64'hDDDD_EEEE_FFFF_0001);
        idle(RAM_LAT + 3);
        clr_start = 1'b1;
        @(posedge clk);
        #1;
        clr_start = 1'b0;
        repeat (101) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("midsweep_rst_flags",
              {58'd0, wr_ready, rd_ready, rd_valid, busy, clr_done, sat_flag}, 64'b110000);
        check("midsweep_rst_data", rd_data, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", {62'd0, wr_ready, busy}, 64'b10);
        for (int i = 0; i < 100; i++) model[i] = '0;
        read_check("swept_99", 99, model[99]);
        read_check("kept_100", 100, model[100]);
        read_check("kept_101", 101, model[101]);
        read_check("kept_511", 511, model[511]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/simd_accumulator.md
Name: simd_accumulator

Overview:
- Next-generation read-modify-write accumulator bank in front of a pseudo-dual-port RAM (one write port, one read port).
- Adds per-lane SIMD arithmetic with a parametrised lane width and selectable op (overwrite / add / subtract / saturating add).
- Handles a RAM read latency of 1 or 2 with full hazard forwarding, arbitrates the read port with backpressure, and provides a hardware clear sweep.
- Sits between the compute datapath, which issues accumulate writes, and the result drain, which issues reads.

Parameters:
ADDR_WIDTH, 9, RAM address width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 64, RAM word width; must be a multiple of LANE_WIDTH
LANE_WIDTH, 16, SIMD lane width (8, 16 or 32)
RAM_LAT, 2, RAM read latency in cycles (1 or 2)

Ports:
clk  in  1  sole clock
rstn  in  1  asynchronous active-low reset
wr_en  in  1  accumulate request valid
wr_ready  out  1  request accepted when wr_en && wr_ready
wr_op  in  2  00 overwrite, 01 wrap add, 10 wrap sub (mem - data), 11 signed saturating add
wr_addr  in  ADDR_WIDTH  target word
wr_data  in  DATA_WIDTH  operand, packed lanes, lane 0 in the LSBs
rd_en  in  1  external read request
rd_ready  out  1  read accepted when rd_en && rd_ready
rd_addr  in  ADDR_WIDTH  read address
rd_valid  out  1  rd_data valid, exactly RAM_LAT cycles after acceptance
rd_data  out  DATA_WIDTH  read data
clr_start  in  1  single-cycle pulse: zero the whole RAM
busy  out  1  clear in progress (DRAIN or CLEAR state)
clr_done  out  1  one-cycle pulse when the sweep finishes
sat_flag  out  1  pulses in the ALU cycle when any lane of a saturating op clipped

Behaviour:
- Reset: wr_ready=1, rd_ready=1; rd_valid, busy, clr_done, sat_flag=0; rd_data=0; pipeline, history and FSM cleared.
- RAM contents are not reset.
- Accept cycle T0: if wr_op != 00, issue an internal RAM read of wr_addr at T0.
- Read arbitration: the internal read has priority, so rd_ready=0 in any cycle where wr_en && wr_ready && wr_op != 00.
- A stalled external read is held by the requester; no read is dropped silently.
- ALU stage at T0+RAM_LAT, per lane:
  - 00 result = data.
  - 01 result = base + data, mod 2**LANE_WIDTH.
  - 10 result = base - data, mod 2**LANE_WIDTH.
  - 11 result = signed add clamped to [-2**(LANE_WIDTH-1), 2**(LANE_WIDTH-1)-1].
  - No carries cross lane boundaries.
- The ALU result is registered at T0+RAM_LAT+1, and the RAM write is issued in that same cycle.
- Write-to-RAM latency is RAM_LAT+1 cycles.
- Forwarding:
  - Base comes from the youngest in-flight result whose address matches and which was accepted within the previous RAM_LAT+1 cycles; otherwise base is the RAM read data.
  - Required result: identical to executing every accepted op strictly in order.
  - Back-to-back same-address ops at full rate (one per cycle) must accumulate correctly.
- External reads return RAM contents as of the read edge; they are not forwarded. Software reads only after the pipeline drains (RAM_LAT+1 idle cycles).
- FSM states: IDLE, DRAIN, CLEAR.
  - IDLE: on clr_start go to DRAIN; wr_ready=0 and rd_ready=0 from the next cycle.
  - DRAIN: wait until no op is in flight (at most RAM_LAT+1 cycles), then go to CLEAR with the address counter at 0.
  - CLEAR: write zero to the counter address each cycle and increment. At address 2**ADDR_WIDTH-1, write it, pulse clr_done, return to IDLE, and restore wr_ready=1 and rd_ready=1 in the following cycle.
  - busy=1 in DRAIN and CLEAR.
  - clr_start while busy is ignored.
  - clr_start in the same cycle as an accepted wr_en: the write is accepted and then cleared by the sweep.
- Reset mid-sweep or mid-pipeline: all state is abandoned immediately; in-flight RAM writes are suppressed from the reset assertion onward.
- Accepted reads in flight when a clear begins still complete with rd_valid.

Decomposition:
- Package simd_acc_pkg: acc_op_t enum (OP_WR, OP_ADD, OP_SUB, OP_SADD), the pipeline-stage struct (valid, op, addr, data), the history-entry struct (valid, addr, data), and the clr_state_t enum.
- Sub-module acc_lane_alu, parametrised by LANE_WIDTH. It is purely combinational per lane and returns the result and a saturation bit; the top generates DATA_WIDTH/LANE_WIDTH instances and ORs the saturation bits into sat_flag.
- The RAM is instantiated in the top, using the existing pseudo_dpram, or the vendor IP under USE_IP.

Test Plan:
- Overwrite then add: op00 addr5 data 0x0001_0002_0003_0004, then op01 addr5 same data -> RAM[5] = 0x0002_0004_0006_0008 after drain.
- Hazard chain, RAM_LAT 1 and 2: four consecutive op01 to addr7, each lane +1, starting from 0 -> every lane of RAM[7] = 4; also interleave addr7/addr8/addr7 -> 2/1.
- Lane isolation and saturation, LANE_WIDTH=16: base lanes 0x7FFF and 0xFFFF, op11 +1 -> lanes 0x7FFF (sat_flag=1) and 0x0000. The same with op01 -> 0x8000 and 0x0000 (sat_flag=0). op10 on 0x0000 minus 1 -> 0xFFFF.
- Read arbitration: rd_en held with continuous op01 traffic -> rd_ready=0 while it lasts. Once traffic pauses, the read is accepted and rd_valid asserts exactly RAM_LAT cycles later.
- Clear sweep: fill RAM, clr_start -> busy=1 and wr_ready=0. clr_done arrives after the DRAIN cycles plus 2**ADDR_WIDTH cycles, and all reads then return 0. A second clr_start during the sweep is ignored.
- Reset mid-sweep at address 100 -> outputs reach reset values immediately and wr_ready=1 after release. Addresses >=100 keep their old data.
